round_timer: RTL and testbench
==============================

Name: round_timer

Overview:
Parametrised countdown timer for the switch game. It sequences play rounds and break intervals. It counts seconds derived from the system clock through an internal prescaler. It reports phase, remaining time (binary and BCD for HEX displays), round number, and single-cycle timeout and round-done events. It sits between the game control logic (start and round-pass events) and the HexDisplay drivers, and replaces the single-mode 15/5-second timer.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick (1 s at 50 MHz); must be >= 2
CNT_W, 7, width of the remaining-time counter
PLAY_TIME, 15, ticks per play round; 1..10^DIGITS-1
BREAK_TIME, 5, ticks per break interval; 1..10^DIGITS-1
DIGITS, 2, number of BCD digits output
ROUND_W, 6, round counter width
MIN_PLAY, 5, floor for play time (used only with the optional feature)

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
reset_n  in  1  synchronous active-low reset
start  in  1  level-sampled; starts or restarts the game at round 1
round_pass  in  1  one-cycle pulse; player completed the current round
pause  in  1  level; freezes the timer while high
count  out  CNT_W  remaining ticks in the current phase
bcd  out  4*DIGITS  BCD of count; digit 0 = ones in bits [3:0]
phase  out  2  0=IDLE 1=PLAY 2=BREAK 3=OVER
round_num  out  ROUND_W  current round, 0 while IDLE
timeout  out  1  one-cycle pulse on play-time expiry
round_done  out  1  one-cycle pulse on accepted round_pass

Behaviour:
- Reset (reset_n low at clk edge): phase=IDLE, count=0, round_num=0, timeout=0, round_done=0, prescaler=0. Reset has priority over every input.
- Prescaler counts 0..TICK_DIV-1 and emits an internal tick on the cycle it equals TICK_DIV-1, then wraps to 0.
  - Cleared to 0 on every phase load, so the first tick of any phase comes a full TICK_DIV cycles after the load.
  - Holds its value while pause=1 or phase is IDLE/OVER.
- IDLE: start=1 -> PLAY, count=PLAY_TIME, round_num=1.
- PLAY, not paused:
  - round_pass -> BREAK, count=BREAK_TIME, round_num+1 (saturates at all-ones), round_done=1 for one cycle.
  - else tick with count>1 -> count-1.
  - else tick with count==1 -> count=0, phase=OVER, timeout=1 in the same cycle.
- BREAK, not paused: tick with count>1 -> count-1; tick with count==1 -> PLAY, count=PLAY_TIME.
  - round_pass is ignored in BREAK.
- OVER: count holds 0 and round_num holds its final value; start -> PLAY, count=PLAY_TIME, round_num=1.
- pause=1 in PLAY/BREAK: count, prescaler and phase freeze, and round_pass is ignored. pause has no effect in IDLE/OVER.
- start=1 in PLAY/BREAK restarts immediately: PLAY, count=PLAY_TIME, round_num=1, no pulses. start overrides pause and round_pass.
- Same-cycle priority: reset_n > start > pause > round_pass > tick. round_pass beats an expiring tick (no timeout).
- Output latency and timing:
  - count, phase, round_num, timeout and round_done are registered; they update on the edge where the event is sampled.
  - bcd is combinational from count (double-dabble or div/mod); no extra latency.
- count never underflows; it never wraps.

Optional Feature:
ROUND_SPEEDUP_EN
- Defined: each PLAY load for round r (r>=2) uses max(PLAY_TIME-(r-1), MIN_PLAY). The arithmetic is done in CNT_W+ROUND_W bits so it cannot underflow. A restart or start from IDLE/OVER uses PLAY_TIME.
- Undefined: every PLAY load uses PLAY_TIME. MIN_PLAY is unused.

Decomposition:
- Shared package round_timer_pkg holds the phase encodings (PH_IDLE=0, PH_PLAY=1, PH_BREAK=2, PH_OVER=3) and a function returning the play-time load value.
- One sub-module, tick_prescaler, with ports clk, reset_n, clear, enable and tick, parametrised by TICK_DIV.
- BCD conversion stays inline as a function in the package.

Test Plan:
All scenarios use TICK_DIV=4, PLAY_TIME=15, BREAK_TIME=5, DIGITS=2.
- Reset then start -> phase=PLAY, count=15, bcd=0x15, round_num=1. count reads 14 exactly 4 cycles after the load and 0 at 60 cycles; timeout high for exactly 1 cycle; phase=OVER.
- round_pass at count=9 -> phase=BREAK, count=5, round_num=2, round_done for 1 cycle. 20 cycles later: phase=PLAY, count=15.
- pause held 10 cycles at count=12 -> count stays 12 and round_pass is ignored; after release, next decrement comes the remaining prescaler cycles later.
- round_pass in the same cycle as the tick at count==1 -> BREAK, no timeout. start in BREAK -> PLAY, count=15, round_num=1.
- reset_n low for one cycle mid-PLAY -> all outputs take their reset values next edge; start is ignored while reset_n=0.
- With ROUND_SPEEDUP_EN and MIN_PLAY=13, pass rounds 1-4 -> play loads are 15, 14, 13, 13.

Source files
------------

// File: rtl/round_timer_pkg.sv
// Shared definitions for round_timer: phase encodings, play-time load rule and BCD helper.
// The play-time rule honours ROUND_SPEEDUP_EN through its speedup argument.
package round_timer_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_PLAY  = 2'd1,
    PH_BREAK = 2'd2,
    PH_OVER  = 2'd3
  } phase_e;

  // Play load for a round: shrinks by one tick per completed round, floored at min_play.
  function automatic int unsigned play_load(input bit          speedup,
                                            input int unsigned play_time,
                                            input int unsigned min_play,
                                            input int unsigned round);
    int unsigned dec;
    if (!speedup || round < 2) return play_time;
    dec = round - 1;
    if (dec >= play_time || (play_time - dec) < min_play) return min_play;
    return play_time - dec;
  endfunction

  // Eight BCD digits of value, ones digit in bits [3:0]; callers truncate to their width.
  function automatic logic [31:0] bin2bcd(input int unsigned value);
    logic [31:0] res;
    int unsigned v;
    res = '0;
    v   = value;
    for (int unsigned i = 0; i < 8; i++) begin
      res[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 prescaler emitting a one-cycle tick on its last count.
// clear restarts the count; the count holds while enable is low.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(TICK_DIV - 1));
  assign tick   = enable && w_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/round_timer.sv
// Play/break round countdown timer with prescaled seconds, BCD readout and event pulses.
// Optional macro ROUND_SPEEDUP_EN shortens each later play round down to MIN_PLAY.
module round_timer
  import round_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned CNT_W      = 7,
  parameter int unsigned PLAY_TIME  = 15,
  parameter int unsigned BREAK_TIME = 5,
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned ROUND_W    = 6,
  parameter int unsigned MIN_PLAY   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  round_pass,
  input  logic                  pause,
  output logic [CNT_W-1:0]      count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [1:0]            phase,
  output logic [ROUND_W-1:0]    round_num,
  output logic                  timeout,
  output logic                  round_done
);

`ifdef ROUND_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  phase_e             r_phase, w_phase_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [ROUND_W-1:0] r_round, w_round_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_round_done, w_round_done_nxt;
  logic               w_tick, w_clear, w_enable;
  logic [CNT_W-1:0]   w_next_load;

  assign w_enable    = ((r_phase == PH_PLAY) || (r_phase == PH_BREAK)) && !pause;
  assign w_next_load = CNT_W'(play_load(SPEEDUP, PLAY_TIME, MIN_PLAY, 32'(r_round)));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_clear),
    .enable  (w_enable),
    .tick    (w_tick)
  );

  always_comb begin
    w_phase_nxt      = r_phase;
    w_count_nxt      = r_count;
    w_round_nxt      = r_round;
    w_timeout_nxt    = 1'b0;
    w_round_done_nxt = 1'b0;
    w_clear          = 1'b0;
    if (start) begin
      w_phase_nxt = PH_PLAY;
      w_count_nxt = CNT_W'(PLAY_TIME);
      w_round_nxt = ROUND_W'(1);
      w_clear     = 1'b1;
    end else if (!pause) begin
      case (r_phase)
        PH_PLAY: begin
          if (round_pass) begin
            w_phase_nxt      = PH_BREAK;
            w_count_nxt      = CNT_W'(BREAK_TIME);
            w_round_nxt      = (r_round == '1) ? r_round : r_round + ROUND_W'(1);
            w_round_done_nxt = 1'b1;
            w_clear          = 1'b1;
          end else if (w_tick) begin
            if (r_count > CNT_W'(1)) begin
              w_count_nxt = r_count - CNT_W'(1);
            end else begin
              w_count_nxt   = '0;
              w_phase_nxt   = PH_OVER;
              w_timeout_nxt = 1'b1;
            end
          end
        end
        PH_BREAK: begin
          if (w_tick) begin
            if (r_count > CNT_W'(1)) begin
              w_count_nxt = r_count - CNT_W'(1);
            end else begin
              w_phase_nxt = PH_PLAY;
              w_count_nxt = w_next_load;
              w_clear     = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase      <= PH_IDLE;
      r_count      <= '0;
      r_round      <= '0;
      r_timeout    <= 1'b0;
      r_round_done <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_count      <= w_count_nxt;
      r_round      <= w_round_nxt;
      r_timeout    <= w_timeout_nxt;
      r_round_done <= w_round_done_nxt;
    end
  end

  assign count      = r_count;
  assign phase      = r_phase;
  assign round_num  = r_round;
  assign timeout    = r_timeout;
  assign round_done = r_round_done;
  assign bcd        = (4*DIGITS)'(bin2bcd(32'(r_count)));

endmodule

// File: tb/tb_round_timer.sv
// Bench for round_timer: directed scenarios plus random traffic against a cycle-level
// reference model built from the timer's phase rules.
module tb_round_timer;

  localparam int TICK_DIV   = 4;
  localparam int CNT_W      = 7;
  localparam int PLAY_TIME  = 15;
  localparam int BREAK_TIME = 5;
  localparam int DIGITS     = 2;
  localparam int ROUND_W    = 6;
  localparam int MIN_PLAY   = 13;
  localparam int ROUND_MAX  = (1 << ROUND_W) - 1;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                round_pass = 1'b0;
  logic                pause = 1'b0;
  logic [CNT_W-1:0]    count;
  logic [4*DIGITS-1:0] bcd;
  logic [1:0]          phase;
  logic [ROUND_W-1:0]  round_num;
  logic                timeout;
  logic                round_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: 0=IDLE 1=PLAY 2=BREAK 3=OVER
  int m_phase = 0, m_count = 0, m_round = 0, m_pre = 0;
  int m_to = 0, m_done = 0;

  always #5 clk = ~clk;

  round_timer #(
    .TICK_DIV  (TICK_DIV),
    .CNT_W     (CNT_W),
    .PLAY_TIME (PLAY_TIME),
    .BREAK_TIME(BREAK_TIME),
    .DIGITS    (DIGITS),
    .ROUND_W   (ROUND_W),
    .MIN_PLAY  (MIN_PLAY)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .round_pass(round_pass),
    .pause     (pause),
    .count     (count),
    .bcd       (bcd),
    .phase     (phase),
    .round_num (round_num),
    .timeout   (timeout),
    .round_done(round_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_load(input int r);
`ifdef ROUND_SPEEDUP_EN
    int t;
    if (r < 2) return PLAY_TIME;
    t = PLAY_TIME - (r - 1);
    return (t > MIN_PLAY) ? t : MIN_PLAY;
`else
    if (r < 0) return 0;
    return PLAY_TIME;
`endif
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit rp, input bit pa);
    bit tick;
    if (!rst) begin
      m_phase = 0; m_count = 0; m_round = 0; m_pre = 0; m_to = 0; m_done = 0;
      return;
    end
    m_to = 0;
    m_done = 0;
    tick = (m_pre == TICK_DIV - 1);
    if (st) begin
      m_phase = 1; m_count = PLAY_TIME; m_round = 1; m_pre = 0;
    end else if ((m_phase == 1 || m_phase == 2) && !pa) begin
      if (m_phase == 1 && rp) begin
        m_phase = 2; m_count = BREAK_TIME; m_pre = 0; m_done = 1;
        m_round = (m_round + 1 > ROUND_MAX) ? ROUND_MAX : m_round + 1;
      end else if (tick) begin
        m_pre = 0;
        if (m_count > 1) m_count = m_count - 1;
        else if (m_phase == 1) begin
          m_count = 0; m_phase = 3; m_to = 1;
        end else begin
          m_phase = 1; m_count = exp_load(m_round);
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("phase", 32'(phase), m_phase);
    check("count", 32'(count), m_count);
    check("bcd", 32'(bcd), ((m_count / 10) << 4) | (m_count % 10));
    check("round_num", 32'(round_num), m_round);
    check("timeout", 32'(timeout), m_to);
    check("round_done", 32'(round_done), m_done);
  endtask

  task automatic drive(input bit rst, input bit st, input bit rp, input bit pa);
    reset_n = rst; start = st; round_pass = rp; pause = pa;
    @(posedge clk);
    #1;
    model_step(rst, st, rp, pa);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int load_exp [4];
    int c;
`ifdef ROUND_SPEEDUP_EN
    load_exp = '{15, 14, 13, 13};
`else
    load_exp = '{15, 15, 15, 15};
`endif

    // Reset, start, full expiry
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_phase", 32'(phase), 0);
    check("rst_count", 32'(count), 0);
    check("rst_round", 32'(round_num), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("start_phase", 32'(phase), 1);
    check("start_count", 32'(count), 15);
    check("start_bcd", 32'(bcd), 32'h15);
    check("start_round", 32'(round_num), 1);
    idle(3);
    check("pre_first_tick", 32'(count), 15);
    idle(1);
    check("first_tick", 32'(count), 14);
    idle(56);
    check("expire_count", 32'(count), 0);
    check("expire_timeout", 32'(timeout), 1);
    check("expire_phase", 32'(phase), 3);
    idle(1);
    check("timeout_one_cycle", 32'(timeout), 0);
    check("over_hold", 32'(phase), 3);

    // round_pass at count 9, break, next play load
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(24);
    check("at_nine", 32'(count), 9);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("pass_phase", 32'(phase), 2);
    check("pass_count", 32'(count), 5);
    check("pass_round", 32'(round_num), 2);
    check("pass_done", 32'(round_done), 1);
    idle(1);
    check("done_one_cycle", 32'(round_done), 0);
    idle(19);
    check("break_end_phase", 32'(phase), 1);
    check("break_end_count", 32'(count), exp_load(2));

    // pause freezes count and masks round_pass
    idle(14);
    c = exp_load(2) - 3;
    check("pre_pause", 32'(count), c);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, (i == 4), 1'b1);
    check("pause_count", 32'(count), c);
    check("pause_phase", 32'(phase), 1);
    idle(1);
    check("resume_hold", 32'(count), c);
    idle(1);
    check("resume_tick", 32'(count), c - 1);

    // round_pass coinciding with the final tick
    idle(4 * (m_count - 1));
    check("at_one", 32'(count), 1);
    idle(3);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("race_phase", 32'(phase), 2);
    check("race_timeout", 32'(timeout), 0);
    check("race_done", 32'(round_done), 1);
    idle(2);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_phase", 32'(phase), 1);
    check("restart_count", 32'(count), 15);
    check("restart_round", 32'(round_num), 1);

    // mid-PLAY reset wins over start
    idle(6);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("midrst_phase", 32'(phase), 0);
    check("midrst_count", 32'(count), 0);
    check("midrst_round", 32'(round_num), 0);

    // play loads over successive rounds
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      check("round_load", 32'(count), load_exp[r]);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      idle(20);
    end

    // round counter saturation
    for (int r = 0; r < 64; r++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      idle(20);
    end
    check("round_saturate", 32'(round_num), ROUND_MAX);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 14) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
